// File: rtl/pwm_line_feeder.sv
// pwm_line_feeder: buffers upstream intensity words in a small FIFO and emits
// them as start-framed lines of STAGE words, each followed by a GAP-cycle hold
// so the downstream PWM can consume the whole line before the next one arrives.
module pwm_line_feeder #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned STAGE  = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned GAP    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DWIDTH-1:0]          in_data,
  output logic                       in_ready,
  output logic                       start,
  output logic [DWIDTH-1:0]          data,
  output logic                       data_valid,
  output logic                       line_done,
  output logic [$clog2(DEPTH+1)-1:0] fill
);

  localparam int unsigned FW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(STAGE + 1);
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [FW-1:0] DEPTH_F    = FW'(DEPTH);
  localparam logic [FW-1:0] STAGE_F    = FW'(STAGE);
  localparam logic [AW-1:0] PTR_LAST   = AW'(DEPTH - 1);
  localparam logic [CW-1:0] STAGE_C    = CW'(STAGE);
  localparam logic [CW-1:0] WORD_LAST  = CW'(STAGE - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [FW-1:0]     count;
  logic [1:0]        state;
  logic [CW-1:0]     word_cnt;   // words already popped in the current line
  logic [GW-1:0]     gap_cnt;
  logic              push;
  logic              pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + AW'(1);
  endfunction

  assign in_ready = (count != DEPTH_F) && !rst;
  assign push     = in_valid && in_ready;
  assign fill     = count;

  // Pop decision: start a line only with a full line buffered, then drain it.
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = (count >= STAGE_F);
      SEND:    pop = (word_cnt != STAGE_C);
      default: pop = 1'b0;
    endcase
  end

  // FIFO storage; writes are already blocked during reset through in_ready.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep count steady.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + FW'(1);
        2'b01:   count <= count - FW'(1);
        default: count <= count;
      endcase
    end
  end

  // Line sequencer: IDLE waits for a full line, SEND emits it, HOLD spaces lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      word_cnt   <= '0;
      gap_cnt    <= '0;
      start      <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      line_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state      <= SEND;
            data       <= mem[rd_ptr];
            start      <= 1'b1;
            data_valid <= 1'b1;
            line_done  <= (STAGE == 1);
            word_cnt   <= CW'(1);
          end
        end
        SEND: begin
          start <= 1'b0;
          if (pop) begin
            data      <= mem[rd_ptr];
            line_done <= (word_cnt == WORD_LAST);
            word_cnt  <= word_cnt + CW'(1);
          end else begin
            // Last word has been shown; data keeps it through the hold.
            state      <= HOLD;
            data_valid <= 1'b0;
            line_done  <= 1'b0;
            gap_cnt    <= '0;
          end
        end
        HOLD: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
